wb_mailbox: RTL and testbench

Wishbone slave mailbox between the Caravel management SoC bus and the Patmos core. It holds two independent synchronous FIFOs. The host-to-core TX FIFO is filled by Wishbone writes and drained by Patmos through a valid/ready port. The core-to-host RX FIFO is filled by Patmos and drained by Wishbone reads. It sits directly upstream of PatmosChip on the user-area Wishbone port and gives Patmos buffered host communication in place of raw single-register access.

---
 rtl/wb_mailbox_pkg.sv | 44 ++++
 rtl/wb_mailbox_sync_fifo.sv | 84 ++++++++
 rtl/wb_mailbox.sv | 181 ++++++++++++++++++
 tb/tb_wb_mailbox.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mailbox_pkg.sv
// Shared definitions for the Wishbone mailbox: register map, STATUS/CTRL
// bit positions, bus FSM states and the byte-lane masking helper.
package wb_mailbox_pkg;

   // Register index taken from wbs_adr_i[3:2].
   typedef enum logic [1:0] {
      REG_TXDATA = 2'd0,
      REG_RXDATA = 2'd1,
      REG_STATUS = 2'd2,
      REG_CTRL   = 2'd3
   } reg_e;

   // Wishbone slave handshake states.
   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_e;

   // STATUS register layout.
   localparam int STAT_TX_FULL    = 0;
   localparam int STAT_TX_EMPTY   = 1;
   localparam int STAT_RX_FULL    = 2;
   localparam int STAT_RX_EMPTY   = 3;
   localparam int STAT_TX_OVF     = 4;
   localparam int STAT_RX_UNF     = 5;
   localparam int STAT_TX_CNT_LSB = 8;
   localparam int STAT_RX_CNT_LSB = 16;
   localparam int STAT_CNT_W      = 5;

   // CTRL register layout; both bits act as one-shot commands.
   localparam int CTRL_FLUSH      = 0;
   localparam int CTRL_CLR_STICKY = 1;

   // Zero every byte whose select lane is low.
   function automatic logic [31:0] lane_mask(input logic [31:0] data,
                                             input logic [3:0]  sel);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = sel[b] ? data[8*b +: 8] : 8'h00;
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_mailbox_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Full/empty are registered and
// reflect pre-edge state, so a push into a full FIFO is dropped even when a
// pop happens at the same edge. A flush overrides any push or pop.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             full_q;
   logic             empty_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push_i & ~full_q  & ~flush_i;
   assign do_pop  = pop_i  & ~empty_q & ~flush_i;

   // Next occupancy: flush clears, simultaneous push and pop cancel out.
   always_comb begin
      // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
      count_d = count_q;
      if (flush_i) begin
         count_d = '0;
      end else if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CW'(1);
      end
   end

   // Pointers, occupancy and the registered full/empty flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every register here sees pre-edge values.
         if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   // Storage array, written on an accepted push.
   // NOTE: the array is deliberately not reset; data_o is forced to 0 while empty,
   // so stale or uninitialised contents can never reach the output.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = empty_q ? '0 : mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign count_o = count_q;

endmodule

// File: rtl/wb_mailbox.sv
// Wishbone slave mailbox between the management SoC and the Patmos core.
// TX FIFO: host writes, core drains. RX FIFO: core fills, host reads.
// Every accepted access is acknowledged one cycle later and commits all of
// its side effects at the accepting edge.
module wb_mailbox
   import wb_mailbox_pkg::*;
#(
   parameter logic [31:0] BASE  = 32'h3000_0000,
   parameter int          DEPTH = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [31:0] core_rd_data,
   output logic        core_rd_valid,
   input  logic        core_rd_ready,
   input  logic [31:0] core_wr_data,
   input  logic        core_wr_valid,
   output logic        core_wr_ready,
   output logic        irq
);

   localparam int CW = $clog2(DEPTH) + 1;

   // Bus decode.
   logic        hit;
   logic        accept;
   reg_e        reg_idx;
   logic        wr_tx;
   logic        rd_rx;
   logic        wr_ctrl;
   logic        flush;
   logic        clr_sticky;
   logic        unused_adr;

   // FIFO interfaces.
   logic [31:0]   tx_push_data;
   logic          tx_pop;
   logic          tx_full;
   logic          tx_empty;
   logic [CW-1:0] tx_count;
   logic          rx_push;
   logic [31:0]   rx_head;
   logic          rx_full;
   logic          rx_empty;
   logic [CW-1:0] rx_count;

   // Bus FSM, sticky flags and read path.
   bus_state_e  state_q;
   logic        ack_q;
   logic [31:0] dat_q;
   logic        tx_ovf_q;
   logic        rx_unf_q;
   logic [31:0] status_d;
   logic [31:0] rdata_d;

   assign hit     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE[31:4]);
   assign accept  = hit & (state_q == BUS_IDLE);
   assign reg_idx = reg_e'(wbs_adr_i[3:2]);

   assign wr_tx      = accept &  wbs_we_i & (reg_idx == REG_TXDATA);
   assign rd_rx      = accept & ~wbs_we_i & (reg_idx == REG_RXDATA);
   assign wr_ctrl    = accept &  wbs_we_i & (reg_idx == REG_CTRL);
   assign flush      = wr_ctrl & wbs_dat_i[CTRL_FLUSH];
   assign clr_sticky = wr_ctrl & wbs_dat_i[CTRL_CLR_STICKY];

   // Byte offset bits below word granularity carry no meaning here.
   assign unused_adr = ^wbs_adr_i[1:0];

   assign tx_push_data = lane_mask(wbs_dat_i, wbs_sel_i);
   assign tx_pop       = core_rd_valid & core_rd_ready;
   assign rx_push      = core_wr_valid & core_wr_ready;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_tx_fifo (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .push_i  (wr_tx),
      .pop_i   (tx_pop),
      .flush_i (flush),
      .data_i  (tx_push_data),
      .data_o  (core_rd_data),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .count_o (tx_count)
   );

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_rx_fifo (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .push_i  (rx_push),
      .pop_i   (rd_rx),
      .flush_i (flush),
      .data_i  (core_wr_data),
      .data_o  (rx_head),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .count_o (rx_count)
   );

   // STATUS word assembled from FIFO flags, counts and sticky bits.
   always_comb begin
      status_d                              = '0;
      status_d[STAT_TX_FULL]                = tx_full;
      status_d[STAT_TX_EMPTY]               = tx_empty;
      status_d[STAT_RX_FULL]                = rx_full;
      status_d[STAT_RX_EMPTY]               = rx_empty;
      status_d[STAT_TX_OVF]                 = tx_ovf_q;
      status_d[STAT_RX_UNF]                 = rx_unf_q;
      status_d[STAT_TX_CNT_LSB +: CW]       = tx_count;
      status_d[STAT_RX_CNT_LSB +: CW]       = rx_count;
   end

   // Read mux: write-only registers and all writes return 0.
   always_comb begin
      rdata_d = '0;
      if (!wbs_we_i) begin
         case (reg_idx)
            REG_RXDATA: rdata_d = rx_head;
            REG_STATUS: rdata_d = status_d;
            default:    rdata_d = '0;
         endcase
      end
   end

   // Wishbone handshake: accept in IDLE, one-cycle ack, always back to IDLE.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= BUS_IDLE;
         ack_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         case (state_q)
            BUS_IDLE: begin
               if (hit) begin
                  state_q <= BUS_ACK;
                  ack_q   <= 1'b1;
                  dat_q   <= rdata_d;
               end
            end
            BUS_ACK: begin
               state_q <= BUS_IDLE;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

   // Sticky error flags: set by a dropped push or an empty read, cleared via CTRL.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         tx_ovf_q <= 1'b0;
         rx_unf_q <= 1'b0;
      end else if (clr_sticky) begin
         tx_ovf_q <= 1'b0;
         rx_unf_q <= 1'b0;
      end else begin
         if (wr_tx && tx_full)  tx_ovf_q <= 1'b1;
         if (rd_rx && rx_empty) rx_unf_q <= 1'b1;
      end
   end

   assign wbs_ack_o     = ack_q;
   assign wbs_dat_o     = dat_q;
   assign core_rd_valid = ~tx_empty;
   assign core_wr_ready = ~rx_full;
   assign irq           = ~rx_empty;

endmodule

// File: tb/tb_wb_mailbox.sv
// Self-checking bench for wb_mailbox: a vector table of bus accesses plus
// hand-written sequences for FIFO limits, same-edge interactions and reset.
module tb_wb_mailbox;

   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam int          DEPTH = 8;
   localparam logic [31:0] A_TX  = 32'h3000_0000;
   localparam logic [31:0] A_RX  = 32'h3000_0004;
   localparam logic [31:0] A_ST  = 32'h3000_0008;
   localparam logic [31:0] A_CT  = 32'h3000_000C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0;
   logic        cyc = 1'b0;
   logic        we  = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] dat_i = '0;
   logic [31:0] adr = '0;
   logic        ack;
   logic [31:0] dat_o;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [31:0] wr_data = '0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboards: words the core should see from TX, words the host should read from RX.
   logic [31:0] tx_sb [$];
   logic [31:0] rx_sb [$];
   int          tx_cnt_m = 0;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        exp_ack;
      logic [31:0] exp_rd;
      string       name;
   } vec_t;

   vec_t vecs [$];

   always #5 clk = ~clk;

   wb_mailbox #(
      .BASE  (BASE),
      .DEPTH (DEPTH)
   ) dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .wbs_stb_i     (stb),
      .wbs_cyc_i     (cyc),
      .wbs_we_i      (we),
      .wbs_sel_i     (sel),
      .wbs_dat_i     (dat_i),
      .wbs_adr_i     (adr),
      .wbs_ack_o     (ack),
      .wbs_dat_o     (dat_o),
      .core_rd_data  (rd_data),
      .core_rd_valid (rd_valid),
      .core_rd_ready (rd_ready),
      .core_wr_data  (wr_data),
      .core_wr_valid (wr_valid),
      .core_wr_ready (wr_ready),
      .irq           (irq)
   );

   function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic ea, input logic [31:0] er,
                               input string n);
      vec_t v;
      v.we = w; v.adr = a; v.dat = d; v.sel = s; v.exp_ack = ea; v.exp_rd = er; v.name = n;
      return v;
   endfunction

   function automatic logic [31:0] tb_mask(input logic [31:0] d, input logic [3:0] s);
      return d & {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic flush_models();
      tx_sb.delete();
      rx_sb.delete();
      tx_cnt_m = 0;
   endtask

   // One bus access, started at a falling edge; waits at most 4 cycles for ack.
   task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic acked, output int cyc_n,
                            output logic [31:0] rd);
      acked = 1'b0;
      cyc_n = 0;
      rd    = '0;
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         if (ack) begin
            acked = 1'b1;
            cyc_n = c;
            rd    = dat_o;
            break;
         end
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wb_write(input string name, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      logic acked; int n; logic [31:0] rd;
      wb_access(1'b1, a, d, s, acked, n, rd);
      check({name, " ack latency"}, 32'(acked ? n : 0), 32'd1);
   endtask

   task automatic wb_read(input string name, input logic [31:0] a, output logic [31:0] rd);
      logic acked; int n;
      wb_access(1'b0, a, 32'h0, 4'hF, acked, n, rd);
      check({name, " ack latency"}, 32'(acked ? n : 0), 32'd1);
   endtask

   task automatic status(input string name, input logic [31:0] exp);
      logic [31:0] rd;
      wb_read(name, A_ST, rd);
      check(name, rd, exp);
   endtask

   task automatic host_tx(input string name, input logic [31:0] d, input logic [3:0] s);
      if (tx_cnt_m < DEPTH) begin
         tx_sb.push_back(tb_mask(d, s));
         tx_cnt_m++;
      end
      wb_write(name, A_TX, d, s);
   endtask

   task automatic host_rx(input string name);
      logic [31:0] rd;
      wb_read(name, A_RX, rd);
      if (rx_sb.size() > 0) check(name, rd, rx_sb.pop_front());
      else                  check(name, rd, 32'h0);
   endtask

   task automatic core_pop(input string name);
      check_bit({name, " valid"}, rd_valid, 1'b1);
      if (tx_sb.size() > 0) begin
         check({name, " data"}, rd_data, tx_sb.pop_front());
         tx_cnt_m--;
      end else begin
         n_checks++; n_errors++;
         $display("FAIL %s: core pop with no expected word queued", name);
      end
      rd_ready = 1'b1;
      @(posedge clk); #1;
      rd_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic core_push(input string name, input logic [31:0] d);
      check_bit({name, " wr_ready"}, wr_ready, 1'b1);
      wr_valid = 1'b1; wr_data = d;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      rx_sb.push_back(d);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string name);
      check_bit({name, " ack"}, ack, 1'b0);
      check({name, " dat_o"}, dat_o, 32'h0);
      check_bit({name, " irq"}, irq, 1'b0);
      check_bit({name, " rd_valid"}, rd_valid, 1'b0);
      check_bit({name, " wr_ready"}, wr_ready, 1'b1);
      check({name, " rd_data"}, rd_data, 32'h0);
   endtask

   initial begin
      logic        acked;
      int          n;
      logic [31:0] rd;
      logic        ack_seq [4];

      // Register-access vectors applied in order from an idle, empty mailbox.
      vecs.push_back(mk(1'b0, A_ST, 32'h0, 4'hF, 1'b1, 32'h0000_000A, "reset status"));
      vecs.push_back(mk(1'b0, A_TX, 32'h0, 4'hF, 1'b1, 32'h0000_0000, "read txdata"));
      vecs.push_back(mk(1'b0, A_CT, 32'h0, 4'hF, 1'b1, 32'h0000_0000, "read ctrl"));
      vecs.push_back(mk(1'b1, A_ST, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, "write status"));
      vecs.push_back(mk(1'b0, A_ST, 32'h0, 4'hF, 1'b1, 32'h0000_000A, "status after ro write"));
      vecs.push_back(mk(1'b1, 32'h3000_0010, 32'h1111_1111, 4'hF, 1'b0, 32'h0, "outside write"));
      vecs.push_back(mk(1'b0, A_ST, 32'h0, 4'hF, 1'b1, 32'h0000_000A, "status after outside"));
      vecs.push_back(mk(1'b0, 32'h4000_0008, 32'h0, 4'hF, 1'b0, 32'h0, "outside read"));
      vecs.push_back(mk(1'b1, A_TX, 32'h1234_5678, 4'b1100, 1'b1, 32'h0, "tx sel 1100"));
      vecs.push_back(mk(1'b0, A_ST, 32'h0, 4'hF, 1'b1, 32'h0000_0108, "status tx one"));
      vecs.push_back(mk(1'b1, A_CT, 32'h0000_0001, 4'hF, 1'b1, 32'h0, "ctrl flush"));
      vecs.push_back(mk(1'b0, A_ST, 32'h0, 4'hF, 1'b1, 32'h0000_000A, "status after flush"));
      vecs.push_back(mk(1'b0, A_RX, 32'h0, 4'hF, 1'b1, 32'h0000_0000, "rx read empty"));
      vecs.push_back(mk(1'b0, A_ST, 32'h0, 4'hF, 1'b1, 32'h0000_002A, "status underflow"));
      vecs.push_back(mk(1'b1, A_CT, 32'h0000_0002, 4'hF, 1'b1, 32'h0, "ctrl clear sticky"));
      vecs.push_back(mk(1'b0, A_ST, 32'h0, 4'hF, 1'b1, 32'h0000_000A, "status cleared"));

      // Reset values, sampled while reset is held and just after release.
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("in reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("after reset");

      foreach (vecs[i]) begin
         wb_access(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, acked, n, rd);
         check({vecs[i].name, " ack latency"}, 32'(acked ? n : 0),
               vecs[i].exp_ack ? 32'd1 : 32'd0);
         if (!vecs[i].we && vecs[i].exp_ack) check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rd);
         if (vecs[i].we && vecs[i].exp_ack && vecs[i].adr == A_TX) begin
            tx_sb.push_back(tb_mask(vecs[i].dat, vecs[i].sel));
            tx_cnt_m++;
         end
         if (vecs[i].we && vecs[i].exp_ack && vecs[i].adr == A_CT && vecs[i].dat[0]) flush_models();
      end

      // Held strobe: ack pulses 1,0,1,0 as the slave re-accepts from IDLE.
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_ST; sel = 4'hF;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         ack_seq[c] = ack;
      end
      stb = 1'b0; cyc = 1'b0;
      check_bit("held stb ack0", ack_seq[0], 1'b1);
      check_bit("held stb ack1", ack_seq[1], 1'b0);
      check_bit("held stb ack2", ack_seq[2], 1'b1);
      check_bit("held stb ack3", ack_seq[3], 1'b0);
      @(posedge clk);
      @(negedge clk);

      // TXDATA with partial lanes: valid appears right after the commit edge.
      check_bit("tx valid before push", rd_valid, 1'b0);
      tx_sb.push_back(tb_mask(32'hDEAD_BEEF, 4'b0011));
      tx_cnt_m++;
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = A_TX; dat_i = 32'hDEAD_BEEF; sel = 4'b0011;
      @(posedge clk); #1;
      check_bit("deadbeef ack", ack, 1'b1);
      check_bit("deadbeef valid next cycle", rd_valid, 1'b1);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      core_pop("deadbeef pop");
      check_bit("valid after pop", rd_valid, 1'b0);

      // Nine writes into an 8-deep TX FIFO: the ninth is dropped and flagged.
      for (int i = 0; i < 9; i++) host_tx($sformatf("tx fill %0d", i), 32'hA000_0000 + 32'(i), 4'hF);
      status("status tx overflow", 32'h0000_0819);
      for (int i = 0; i < DEPTH; i++) core_pop($sformatf("tx drain %0d", i));
      check_bit("tx drained valid", rd_valid, 1'b0);
      check("tx scoreboard leftover", 32'(tx_sb.size()), 32'd0);
      wb_write("clear ovf", A_CT, 32'h2, 4'hF);
      status("status ovf cleared", 32'h0000_000A);

      // RX path: core pushes, host reads in order, then an empty read underflows.
      core_push("rx push 11", 32'h0000_0011);
      check_bit("irq after push", irq, 1'b1);
      core_push("rx push 22", 32'h0000_0022);
      status("status rx two", 32'h0002_0002);
      host_rx("rx read 1");
      host_rx("rx read 2");
      host_rx("rx read empty");
      status("status rx underflow", 32'h0000_002A);
      check_bit("irq after drain", irq, 1'b0);
      wb_write("clear unf", A_CT, 32'h2, 4'hF);
      status("status unf cleared", 32'h0000_000A);

      // Both FIFOs full; core pops TX on the same edge as a host TX push.
      for (int i = 0; i < DEPTH; i++) core_push($sformatf("rx fill %0d", i), 32'hB000_0000 + 32'(i));
      check_bit("rx full wr_ready", wr_ready, 1'b0);
      for (int i = 0; i < DEPTH; i++) host_tx($sformatf("tx refill %0d", i), 32'hC000_0000 + 32'(i), 4'hF);
      check_bit("same edge valid", rd_valid, 1'b1);
      check("same edge head", rd_data, tx_sb.pop_front());
      tx_cnt_m--;
      rd_ready = 1'b1;
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = A_TX; dat_i = 32'hBAD0_0000; sel = 4'hF;
      @(posedge clk); #1;
      rd_ready = 1'b0;
      check_bit("same edge ack", ack, 1'b1);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      status("status same edge", 32'h0008_0714);
      for (int i = 0; i < DEPTH - 1; i++) core_pop($sformatf("tx after drop %0d", i));
      check_bit("tx empty after drop", rd_valid, 1'b0);
      wb_write("flush and clear", A_CT, 32'h3, 4'hF);
      flush_models();
      status("status after flush3", 32'h0000_000A);
      check_bit("irq after flush", irq, 1'b0);

      // CTRL flush on the same edge as a core push: the push is discarded.
      wr_valid = 1'b1; wr_data = 32'h0000_0033;
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = A_CT; dat_i = 32'h1; sel = 4'hF;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      check_bit("flush vs push ack", ack, 1'b1);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      status("status flush vs push", 32'h0000_000A);
      check_bit("irq flush vs push", irq, 1'b0);

      // Reset asserted in the ack cycle aborts the transfer.
      host_tx("pre reset tx", 32'h0000_00AA, 4'hF);
      core_push("pre reset rx", 32'h0000_0055);
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_ST; sel = 4'hF;
      @(posedge clk); #1;
      check_bit("pre reset accept", ack, 1'b1);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid transfer reset");
      stb = 1'b0; cyc = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      flush_models();
      @(negedge clk);
      check_reset_outputs("after mid reset");
      status("status after mid reset", 32'h0000_000A);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global time limit so a stuck run still ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
